rx_lane_pattern_checker: RTL and testbench
==========================================

// Module: rx_lane_pattern_checker
// PURPOSE
// - MBINIT receiver-side per-lane pattern checker; it produces the 16-bit per-lane pass/fail vector that lane setup consumes.
// - Compares each received mainband data lane against a locally generated expected pattern over a fixed window of valid beats.
// - Counts errors per lane and reports pass/fail per lane with a done handshake.
// PARAMETERS
// - NUM_LANES      16         number of data lanes checked (one bit per lane per beat)
// - COMPARE_LEN    128        valid beats per check window (>=1)
// - ERR_W          8          width of each per-lane error counter
// - ERR_THRESHOLD  0          lane passes when its error count <= ERR_THRESHOLD
// - LFSR_SEED      23'h7FFFFF PRBS seed; must be nonzero
// PORTS
// - CLK            in   1          clock
// - rst_n          in   1          reset, asynchronous, active-low
// - start_check    in   1          level; high requests and holds a check
// - i_rx_valid     in   1          i_rx_data valid this cycle
// - i_rx_data      in   NUM_LANES  one received bit per lane
// - o_lane_result  out  NUM_LANES  1 = lane passed; 0 = lane failed or no result
// - o_done_check   out  1          result valid; held until start_check drops
// BEHAVIOUR
// - Reset values:
//   - o_lane_result = 0, o_done_check = 0, state IDLE, all counters 0.
//   - Expected-pattern generator = LFSR_SEED (or 0 without the macro).
// - FSM states: IDLE, COMPARE, DONE.
//   - IDLE -> COMPARE on start_check = 1.
//     - On entry: clear error counters and beat counter, reload pattern generator, clear o_lane_result.
//   - COMPARE: on each cycle with i_rx_valid = 1:
//     - err[i] += (i_rx_data[i] ^ exp_bit); err saturates at all-ones.
//     - Advance the pattern generator one step; beat_cnt += 1.
//     - Cycles with i_rx_valid = 0 have no effect.
//   - COMPARE -> DONE on the edge that samples the COMPARE_LEN-th valid beat.
//     - That beat's error is included.
//     - o_lane_result[i] = (final err[i] <= ERR_THRESHOLD) and o_done_check = 1 on this same edge, one cycle after the last beat is presented.
//   - DONE: hold o_lane_result and o_done_check while start_check = 1; ignore i_rx_valid.
//   - DONE -> IDLE on start_check = 0.
//     - o_done_check drops on that edge; o_lane_result is held until the next IDLE -> COMPARE.
// - Abort: start_check = 0 during COMPARE -> IDLE next edge.
//   - o_lane_result = 0, o_done_check stays 0; partial counts are discarded.
// - All lanes share one expected bit per beat (exp_bit).
// - beat_cnt width is clog2(COMPARE_LEN+1); it never wraps within a window.
// - Reset mid-check: returns to reset values immediately (asynchronous).
// CONFIGURATION
// - Macro RX_LANE_CHECK_PRBS_EN:
//   - Defined: exp_bit = bit 22 of a 23-bit Fibonacci LFSR, polynomial x^23+x^18+1, seeded with LFSR_SEED.
//     - Shift: lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
//   - Undefined: exp_bit is a toggle pattern, 0 on the first valid beat, then alternating 1, 0, ...
//     - LFSR_SEED is unused.
// TESTING
// - Clean stream from a reference pattern model, 128 contiguous valid beats -> o_lane_result = 16'hFFFF, o_done_check = 1 one cycle after beat 128.
// - As above, lane 3 inverted on beat 10 only, ERR_THRESHOLD = 0 -> o_lane_result = 16'hFFF7.
// - Lanes 15:8 stuck at 0 for the whole window -> o_lane_result = 16'h00FF; with ERR_W = 4, lane counters saturate at 15.
// - 64 valid beats, 20 cycles of i_rx_valid = 0, then 64 valid beats (clean) -> 16'hFFFF; done only after valid beat 128.
// - start_check dropped after beat 50 -> IDLE, o_done_check = 0, o_lane_result = 0; restart with a clean window -> 16'hFFFF.
// - In DONE, drop start_check -> o_done_check = 0 next edge, o_lane_result unchanged; rst_n pulsed mid-COMPARE -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_lane_pattern_checker.sv
// MBINIT receive-side per-lane pattern checker with per-lane error counts.
// Define RX_LANE_CHECK_PRBS_EN for a PRBS23 expected pattern; otherwise a toggle pattern is used.
module rx_lane_pattern_checker #(
    parameter int          NUM_LANES     = 16,
    parameter int          COMPARE_LEN   = 128,
    parameter int          ERR_W         = 8,
    parameter int          ERR_THRESHOLD = 0,
    parameter logic [22:0] LFSR_SEED     = 23'h7FFFFF
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 start_check,
    input  logic                 i_rx_valid,
    input  logic [NUM_LANES-1:0] i_rx_data,
    output logic [NUM_LANES-1:0] o_lane_result,
    output logic                 o_done_check
);

    localparam int            BW   = $clog2(COMPARE_LEN + 1);
    localparam logic [BW-1:0] LAST = BW'(COMPARE_LEN - 1);

    if (LFSR_SEED == 23'd0) begin : g_seed_chk
        $error("LFSR_SEED must be nonzero");
    end

`ifdef RX_LANE_CHECK_PRBS_EN
    localparam int            GW       = 23;
    localparam logic [GW-1:0] GEN_INIT = LFSR_SEED;
`else
    localparam int            GW       = 1;
    localparam logic [GW-1:0] GEN_INIT = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t               state;
    logic [BW-1:0]        beat_cnt;
    logic [GW-1:0]        gen;
    logic [GW-1:0]        gen_next;
    logic                 exp_bit;
    logic [ERR_W-1:0]     err     [NUM_LANES];
    logic [ERR_W-1:0]     err_nxt [NUM_LANES];
    logic [NUM_LANES-1:0] pass;

`ifdef RX_LANE_CHECK_PRBS_EN
    assign gen_next = {gen[21:0], gen[22] ^ gen[17]};
`else
    assign gen_next = ~gen;
`endif
    assign exp_bit = gen[GW-1];

    // next error counts and the pass vector that would result from this beat
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            err_nxt[i] = err[i];
            if ((i_rx_data[i] ^ exp_bit) && (err[i] != '1))
                err_nxt[i] = err[i] + ERR_W'(1);
            pass[i] = int'(err_nxt[i]) <= ERR_THRESHOLD;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            gen           <= GEN_INIT;
            o_lane_result <= '0;
            o_done_check  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++)
                err[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_check) begin
                        state         <= COMPARE;
                        beat_cnt      <= '0;
                        gen           <= GEN_INIT;
                        o_lane_result <= '0;
                        for (int i = 0; i < NUM_LANES; i++)
                            err[i] <= '0;
                    end
                end
                COMPARE: begin
                    if (!start_check) begin
                        state         <= IDLE;
                        o_lane_result <= '0;
                    end else if (i_rx_valid) begin
                        err      <= err_nxt;
                        gen      <= gen_next;
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == LAST) begin
                            state         <= DONE;
                            o_lane_result <= pass;
                            o_done_check  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start_check) begin
                        state        <= IDLE;
                        o_done_check <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_lane_pattern_checker.sv
// Bench for rx_lane_pattern_checker: directed vector table plus random windows.
// Expected results come from a per-lane error-count model over the stored window.
module tb_rx_lane_pattern_checker;

    localparam int N     = 16;
    localparam int LEN   = 128;
    localparam int ERR_W = 8;
    localparam int THR   = 0;

    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_check = 1'b0;
    logic         i_rx_valid = 1'b0;
    logic [N-1:0] i_rx_data = '0;
    logic [N-1:0] o_lane_result;
    logic         o_done_check;

    int tests = 0;
    int fails = 0;

    logic         pat [LEN];
    logic [N-1:0] win [LEN];

    typedef struct {
        string        name;
        logic [N-1:0] inv_mask;
        int           inv_beat;
        logic [N-1:0] stuck0;
        int           gap_at;
        int           gap_len;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vt [6];

    always #5 CLK = ~CLK;

    rx_lane_pattern_checker #(
        .NUM_LANES    (N),
        .COMPARE_LEN  (LEN),
        .ERR_W        (ERR_W),
        .ERR_THRESHOLD(THR),
        .LFSR_SEED    (23'h7FFFFF)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .start_check  (start_check),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_lane_result(o_lane_result),
        .o_done_check (o_done_check)
    );

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] clean(input int k);
        return {N{pat[k]}};
    endfunction

    // lane passes when its saturated mismatch count is within threshold
    function automatic logic [N-1:0] model();
        logic [N-1:0] r;
        int e;
        int emax;
        emax = (1 << ERR_W) - 1;
        r = '0;
        for (int l = 0; l < N; l++) begin
            e = 0;
            for (int k = 0; k < LEN; k++)
                if (win[k][l] !== pat[k]) e++;
            if (e > emax) e = emax;
            r[l] = (e <= THR);
        end
        return r;
    endfunction

    task automatic run_window(input string name, input logic [N-1:0] exp,
                              input int gap_at, input int gap_len,
                              input bit rand_gaps);
        start_check = 1'b1;
        i_rx_valid  = 1'b0;
        @(posedge CLK); #1;
        for (int k = 0; k < LEN; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) begin
                    i_rx_valid = 1'b0;
                    i_rx_data  = N'($urandom);
                    @(posedge CLK); #1;
                end
            end
            if (rand_gaps && ($urandom_range(3) == 0)) begin
                repeat ($urandom_range(3)) begin
                    i_rx_valid = 1'b0;
                    i_rx_data  = N'($urandom);
                    @(posedge CLK); #1;
                end
            end
            if (k == 0)
                check({name, " result cleared"}, o_lane_result, '0);
            if (k == LEN - 1)
                check({name, " done early"}, {15'd0, o_done_check}, 16'd0);
            i_rx_valid = 1'b1;
            i_rx_data  = win[k];
            @(posedge CLK); #1;
        end
        i_rx_valid = 1'b0;
        check({name, " done"}, {15'd0, o_done_check}, 16'd1);
        check({name, " result"}, o_lane_result, exp);
    endtask

    task automatic hold_release(input string name, input logic [N-1:0] exp);
        repeat (3) begin
            i_rx_valid = 1'b1;
            i_rx_data  = N'($urandom);
            @(posedge CLK); #1;
        end
        i_rx_valid = 1'b0;
        check({name, " hold done"}, {15'd0, o_done_check}, 16'd1);
        check({name, " hold result"}, o_lane_result, exp);
        start_check = 1'b0;
        @(posedge CLK); #1;
        check({name, " release done"}, {15'd0, o_done_check}, 16'd0);
        check({name, " release result"}, o_lane_result, exp);
    endtask

    initial begin
        logic [22:0] lfsr;
        logic [N-1:0] exp;
        lfsr = 23'h7FFFFF;
        for (int k = 0; k < LEN; k++) begin
`ifdef RX_LANE_CHECK_PRBS_EN
            pat[k] = lfsr[22];
            lfsr   = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
`else
            pat[k] = (k % 2) == 1;
`endif
        end

        vt[0] = '{"clean",     16'h0000, -1,  16'h0000, -1, 0,  16'hFFFF};
        vt[1] = '{"lane3_b10", 16'h0008, 10,  16'h0000, -1, 0,  16'hFFF7};
        vt[2] = '{"stuck_hi",  16'h0000, -1,  16'hFF00, -1, 0,  16'h00FF};
        vt[3] = '{"gap20",     16'h0000, -1,  16'h0000, 64, 20, 16'hFFFF};
        vt[4] = '{"lane0_b127",16'h0001, 127, 16'h0000, -1, 0,  16'hFFFE};
        vt[5] = '{"lane15_b0", 16'h8000, 0,   16'h0000, -1, 0,  16'h7FFF};

        repeat (2) @(posedge CLK);
        #1;
        check("reset result", o_lane_result, '0);
        check("reset done", {15'd0, o_done_check}, 16'd0);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < LEN; k++) begin
                win[k] = clean(k) & ~vt[v].stuck0;
                if (k == vt[v].inv_beat) win[k] = win[k] ^ vt[v].inv_mask;
            end
            run_window(vt[v].name, vt[v].exp, vt[v].gap_at, vt[v].gap_len, 1'b0);
            hold_release(vt[v].name, vt[v].exp);
        end

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < LEN; k++)
                win[k] = clean(k) ^ N'($urandom & $urandom & $urandom & $urandom
                                       & $urandom & $urandom & $urandom);
            exp = model();
            run_window("random", exp, -1, 0, 1'b1);
            hold_release("random", exp);
        end

        // abort after 50 beats with lane 5 corrupted, then a clean restart
        start_check = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 50; k++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = clean(k) ^ 16'h0020;
            @(posedge CLK); #1;
        end
        i_rx_valid  = 1'b0;
        start_check = 1'b0;
        @(posedge CLK); #1;
        check("abort done", {15'd0, o_done_check}, 16'd0);
        check("abort result", o_lane_result, '0);
        repeat (2) @(posedge CLK);
        #1;
        check("abort idle done", {15'd0, o_done_check}, 16'd0);
        for (int k = 0; k < LEN; k++) win[k] = clean(k);
        run_window("restart", 16'hFFFF, -1, 0, 1'b0);

        // asynchronous reset while in DONE with a nonzero result
        #2 rst_n = 1'b0;
        #1;
        check("rst in done result", o_lane_result, '0);
        check("rst in done done", {15'd0, o_done_check}, 16'd0);
        start_check = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // asynchronous reset mid-COMPARE with lane 2 erroring, then clean window
        start_check = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 60; k++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = clean(k) ^ 16'h0004;
            @(posedge CLK); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst mid result", o_lane_result, '0);
        check("rst mid done", {15'd0, o_done_check}, 16'd0);
        i_rx_valid  = 1'b0;
        start_check = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        @(posedge CLK); #1;
        run_window("post reset", 16'hFFFF, -1, 0, 1'b0);
        hold_release("post reset", 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
